// File: rtl/fetch_unit_pkg.sv
// Shared CPU-side definitions for the instruction fetch stage: reset vector,
// fetch FSM encoding and the redirect-type priority used by the target mux.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

    // Higher encoding wins when several D-stage redirect flags are set together.
    typedef enum logic [1:0] {
        JT_BRANCH = 2'd1,
        JT_JUMP   = 2'd2,
        JT_JR     = 2'd3
    } jump_type_e;

    function automatic jump_type_e jump_type(input logic is_jr, input logic is_jump);
        if (is_jr)
            return JT_JR;
        else if (is_jump)
            return JT_JUMP;
        else
            return JT_BRANCH;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bundle between the fetch unit and imem.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit_npc.sv
// Redirect target calculation for the instruction in D (jr > jump > branch).
module npc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] fd_pc,
    input  logic        d_jump,
    input  logic        d_jr,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_rs_val,
    output logic [31:0] target
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    jump_type_e  jt;

    assign pc_plus4  = fd_pc + INSTR_BYTES;
    assign br_offset = {{14{d_imm16[15]}}, d_imm16, 2'b00};

    always_comb begin
        jt     = jump_type(d_jr, d_jump);
        target = pc_plus4 + br_offset;
        case (jt)
            JT_JR:   target = d_rs_val;
            JT_JUMP: target = {pc_plus4[31:28], d_imm26, 2'b00};
            default: target = pc_plus4 + br_offset;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-entry skid for stalled returns, pending
// redirect for branches resolved during a fetch bubble, and the F/D register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_unit_if.master       bus,
    input  logic               stall,
    input  logic               d_branch,
    input  logic               cmp_out,
    input  logic               d_jump,
    input  logic               d_jr,
    input  logic [15:0]        d_imm16,
    input  logic [25:0]        d_imm26,
    input  logic [31:0]        d_rs_val,
    output logic [31:0]        fd_instr,
    output logic [31:0]        fd_pc,
    output logic               fd_valid
);

    fetch_state_e state, state_next;

    logic [31:0] pc;
    logic [31:0] skid;
    logic        pend_valid;
    logic [31:0] pend_target;

    logic        issue;
    logic        bubble;
    logic        capture_skid;
    logic        req;
    logic [31:0] issue_word;
    logic        redirect_now;
    logic [31:0] target;
    logic [31:0] pc_next;

    npc u_npc (
        .fd_pc    (fd_pc),
        .d_jump   (d_jump),
        .d_jr     (d_jr),
        .d_imm16  (d_imm16),
        .d_imm26  (d_imm26),
        .d_rs_val (d_rs_val),
        .target   (target)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_REQ;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        req          = 1'b0;
        issue        = 1'b0;
        bubble       = 1'b0;
        capture_skid = 1'b0;
        issue_word   = skid;
        case (state)
            ST_REQ: begin
                req        = 1'b1;
                issue_word = bus.imem_rdata;
                if (!stall) begin
                    if (bus.imem_ready)
                        issue = 1'b1;
                    else
                        bubble = 1'b1;
                end else if (bus.imem_ready) begin
                    capture_skid = 1'b1;
                    state_next   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    issue      = 1'b1;
                    state_next = ST_REQ;
                end
            end
        endcase
    end

    // Branch operands are only trusted once the hazard unit releases D.
    assign redirect_now = fd_valid & ~stall & (d_jr | d_jump | (d_branch & cmp_out));

    always_comb begin
        pc_next = pc + INSTR_BYTES;
        if (redirect_now)
            pc_next = target;
        else if (pend_valid)
            pc_next = pend_target;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            skid        <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            fd_instr    <= '0;
            fd_pc       <= '0;
            fd_valid    <= 1'b0;
        end else begin
            if (capture_skid)
                skid <= bus.imem_rdata;
            if (issue) begin
                fd_instr   <= issue_word;
                fd_pc      <= pc;
                fd_valid   <= 1'b1;
                pc         <= pc_next;
                pend_valid <= 1'b0;
            end else begin
                if (bubble)
                    fd_valid <= 1'b0;
                // The delay slot has not been fetched yet; remember where to go after it.
                if (redirect_now) begin
                    pend_valid  <= 1'b1;
                    pend_target <= target;
                end
            end
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for the main flow plus
// hand-written sequences for pending redirect, reset in HOLD and backward branch.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk;
    logic        reset_n;
    logic        stall, d_branch, cmp_out, d_jump, d_jr;
    logic [15:0] d_imm16;
    logic [25:0] d_imm26;
    logic [31:0] d_rs_val;
    logic [31:0] fd_instr, fd_pc;
    logic        fd_valid;

    int checks_total;
    int checks_passed;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.master),
        .stall    (stall),
        .d_branch (d_branch),
        .cmp_out  (cmp_out),
        .d_jump   (d_jump),
        .d_jr     (d_jr),
        .d_imm16  (d_imm16),
        .d_imm26  (d_imm26),
        .d_rs_val (d_rs_val),
        .fd_instr (fd_instr),
        .fd_pc    (fd_pc),
        .fd_valid (fd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a word derived from its address so F/D contents are traceable.
    always_comb bus.imem_rdata = bus.imem_addr ^ K;

    typedef struct {
        logic        stall, ready, br, cmp, jmp, jr;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [31:0] rs;
        logic [31:0] e_addr;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_fdpc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp)
            checks_passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic s, input logic r, input logic br, input logic c,
                         input logic j, input logic jr, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rs);
        stall          = s;
        bus.imem_ready = r;
        d_branch       = br;
        cmp_out        = c;
        d_jump         = j;
        d_jr           = jr;
        d_imm16        = i16;
        d_imm26        = i26;
        d_rs_val       = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic br, input logic c,
                                input logic j, input logic jr, input logic [15:0] i16,
                                input logic [25:0] i26, input logic [31:0] rs,
                                input logic [31:0] ea, input logic erq, input logic ev,
                                input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.ready = r; v.br = br; v.cmp = c; v.jmp = j; v.jr = jr;
        v.imm16 = i16; v.imm26 = i26; v.rs = rs;
        v.e_addr = ea; v.e_req = erq; v.e_valid = ev; v.e_fdpc = ep;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset_n       = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);

        //           st rdy br cmp j jr imm16     imm26       rs            addr          req v  fd_pc
        vecs[0]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3004, 1, 1, 32'h0000_3000);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3008, 1, 1, 32'h0000_3004);
        vecs[2]  = mk(0, 1, 1, 1, 0, 0, 16'h0003, 26'h0,     32'h0,        32'h0000_3014, 1, 1, 32'h0000_3008);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3018, 1, 1, 32'h0000_3014);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_301C, 1, 1, 32'h0000_3018);
        vecs[5]  = mk(0, 0, 1, 1, 0, 0, 16'h0003, 26'h0,     32'h0,        32'h0000_301C, 1, 0, 32'h0000_3018);
        vecs[6]  = mk(0, 0, 1, 1, 0, 0, 16'h0007, 26'h0,     32'h0,        32'h0000_301C, 1, 0, 32'h0000_3018);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3028, 1, 1, 32'h0000_301C);
        vecs[8]  = mk(0, 1, 1, 0, 0, 0, 16'h0005, 26'h0,     32'h0,        32'h0000_302C, 1, 1, 32'h0000_3028);
        vecs[9]  = mk(1, 1, 1, 1, 0, 0, 16'h0005, 26'h0,     32'h0,        32'h0000_302C, 0, 1, 32'h0000_3028);
        vecs[10] = mk(1, 0, 0, 0, 1, 1, 16'h0000, 26'h0,     32'h0000_9000, 32'h0000_302C, 0, 1, 32'h0000_3028);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3030, 1, 1, 32'h0000_302C);
        vecs[12] = mk(0, 1, 0, 0, 1, 1, 16'h0000, 26'h3_0000, 32'h0000_4000, 32'h0000_4000, 1, 1, 32'h0000_3030);
        vecs[13] = mk(0, 1, 0, 0, 1, 0, 16'h0000, 26'h000_0100, 32'h0,     32'h0000_0400, 1, 1, 32'h0000_4000);
        vecs[14] = mk(0, 1, 1, 1, 0, 0, 16'hFFFF, 26'h0,     32'h0,        32'h0000_4000, 1, 1, 32'h0000_0400);
        vecs[15] = mk(0, 1, 0, 0, 0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_4004, 1, 1, 32'h0000_4000);

        do_reset();
        check("reset imem_addr", bus.imem_addr, 32'h0000_3000);
        check("reset imem_req", {31'b0, bus.imem_req}, 32'd1);
        check("reset fd_valid", {31'b0, fd_valid}, 32'd0);
        check("reset fd_pc", fd_pc, 32'h0);
        check("reset fd_instr", fd_instr, 32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].stall, vecs[i].ready, vecs[i].br, vecs[i].cmp, vecs[i].jmp,
                  vecs[i].jr, vecs[i].imm16, vecs[i].imm26, vecs[i].rs);
            tick();
            check($sformatf("v%0d imem_addr", i), bus.imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d imem_req", i), {31'b0, bus.imem_req}, {31'b0, vecs[i].e_req});
            check($sformatf("v%0d fd_valid", i), {31'b0, fd_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d fd_pc", i), fd_pc, vecs[i].e_fdpc);
            check($sformatf("v%0d fd_instr", i), fd_instr, vecs[i].e_fdpc ^ K);
        end

        // Taken branch resolved during a fetch bubble: redirect goes pending.
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0); tick();
        drive(0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0); tick();
        check("pend pre fd_pc", fd_pc, 32'h0000_3004);
        drive(0, 0, 1, 1, 0, 0, 16'h0003, 26'h0, 32'h0); tick();
        check("pend bubble fd_valid", {31'b0, fd_valid}, 32'd0);
        check("pend bubble addr", bus.imem_addr, 32'h0000_3008);
        check("pend_valid set", {31'b0, dut.pend_valid}, 32'd1);
        check("pend_target", dut.pend_target, 32'h0000_3014);
        drive(0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0); tick();
        check("delay slot fd_pc", fd_pc, 32'h0000_3008);
        check("delay slot fd_valid", {31'b0, fd_valid}, 32'd1);
        check("after slot addr", bus.imem_addr, 32'h0000_3014);
        check("pend_valid cleared", {31'b0, dut.pend_valid}, 32'd0);

        // Build HOLD with a pending redirect, then reset asynchronously.
        drive(0, 0, 1, 1, 0, 0, 16'h0001, 26'h0, 32'h0); tick();
        check("pend2 set", {31'b0, dut.pend_valid}, 32'd1);
        check("pend2 target", dut.pend_target, 32'h0000_3010);
        drive(1, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0); tick();
        check("hold imem_req", {31'b0, bus.imem_req}, 32'd0);
        check("hold addr", bus.imem_addr, 32'h0000_3014);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset addr", bus.imem_addr, 32'h0000_3000);
        check("async reset req", {31'b0, bus.imem_req}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        tick();
        reset_n = 1'b1;
        #1;
        check("post reset addr", bus.imem_addr, 32'h0000_3000);
        check("post reset fd_valid", {31'b0, fd_valid}, 32'd0);
        check("post reset pend_valid", {31'b0, dut.pend_valid}, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0); tick();
        check("first fetch fd_pc", fd_pc, 32'h0000_3000);
        check("first fetch fd_instr", fd_instr, 32'h0000_3000 ^ K);
        check("first fetch addr", bus.imem_addr, 32'h0000_3004);

        // Backward branch with offset -1 from fd_pc 3004 targets itself.
        drive(0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0); tick();
        check("bb pre fd_pc", fd_pc, 32'h0000_3004);
        drive(0, 1, 1, 1, 0, 0, 16'hFFFF, 26'h0, 32'h0); tick();
        check("bb target addr", bus.imem_addr, 32'h0000_3004);
        check("bb slot fd_pc", fd_pc, 32'h0000_3008);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
